// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: the read-side initiator for the instruction memory.
// It keeps at most one read in flight, buffers responses in a 2-entry FIFO and
// hands them to decode over a valid/ready handshake. It supports redirect and halt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | fetching allowed (issue still gated by halt/redirect/space)
// ST_HALT | halt held and no read outstanding; pipeline quiescent
module instr_fetch_unit #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 2048,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd,
  output logic              mem_wn,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(MEM_WORDS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              drop_q;
  logic [1:0]        count_q;
  logic [DATA_W-1:0] instr0_q, instr1_q;
  logic [ADDR_W-1:0] pc0_q, pc1_q;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ_after;
  logic [ADDR_W-1:0] pc_seq;

  // Handshake, response acceptance, issue decision and next PC
  always_comb begin
    pop       = (count_q != 2'd0) & out_ready & ~redirect_valid;
    push      = inflight_q & ~drop_q & ~redirect_valid;
    occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = ~rst & ~redirect_valid & ~halt & (occ_after < 3'd2);
    pc_seq    = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
    pc_d      = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_seq;
    end
  end

  // PC, outstanding-read tracking and discard marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end
      // The redirect cycle discards its own response directly; drop_q keeps a
      // read that was outstanding across the redirect from being pushed later.
      drop_q <= redirect_valid & inflight_q;
    end
  end

  // Two-entry output FIFO; entry 0 is the head and keeps its value when emptied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      instr0_q <= '0;
      pc0_q    <= '0;
      instr1_q <= '0;
      pc1_q    <= '0;
    end else if (redirect_valid) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_q <= mem_read_data;
            pc0_q    <= inflight_pc_q;
            count_q  <= 2'd1;
          end else begin
            instr1_q <= mem_read_data;
            pc1_q    <= inflight_pc_q;
            count_q  <= 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            instr0_q <= instr1_q;
            pc0_q    <= pc1_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            instr0_q <= mem_read_data;
            pc0_q    <= inflight_pc_q;
          end else begin
            instr0_q <= instr1_q;
            pc0_q    <= pc1_q;
            instr1_q <= mem_read_data;
            pc1_q    <= inflight_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Run/halt sequencing: halted only once the last outstanding read has landed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (halt && !inflight_q) state_q <= ST_HALT;
        ST_HALT: if (!halt)               state_q <= ST_RUN;
        default:                          state_q <= ST_RUN;
      endcase
    end
  end

  assign mem_rd      = issue;
  assign mem_wn      = 1'b0;
  assign mem_address = pc_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_instr   = instr0_q;
  assign out_pc      = pc0_q;
  assign busy        = inflight_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a synchronous memory model and
// an expected-PC scoreboard checked on every accepted instruction.
module tb_instr_fetch_unit;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_rd;
  logic              mem_wn;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_read_data = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem [MEM_WORDS];

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
    .mem_read_data(mem_read_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'hA000_0000 + k;
  end

  // Synchronous-read memory: sampled at the issue edge, data valid next cycle
  always @(posedge clk) begin
    if (mem_rd && mem_address < MEM_WORDS) mem_read_data <= mem[mem_address[10:0]];
  end

  // Monitor: memory pin sanity and scoreboard compare on every handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        n_checks++;
        if (mem_address >= MEM_WORDS || mem_wn !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_pins: address %0d wn %b, required address < %0d and wn 0",
                   mem_address, mem_wn, MEM_WORDS);
        end
      end
      if (out_valid && out_ready && !redirect_valid) begin
        logic [ADDR_W-1:0] e;
        n_checks++;
        n_acc++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL accept: got pc %0h, required no delivery", out_pc);
        end else begin
          e = exp_q.pop_front();
          if (out_pc !== e || out_instr !== (32'hA000_0000 + e)) begin
            n_fail++;
            $display("FAIL accept: got pc %0h instr %h, required pc %0h instr %h",
                     out_pc, out_instr, e, 32'hA000_0000 + e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  task automatic start(input logic ready, input int first, input int n);
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_acc = 0;
    out_ready = ready;
    for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'((first + i) % MEM_WORDS));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_issue(input logic [ADDR_W-1:0] a, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_address === a) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: got no issue of %0h in 50 cycles, required issue", nm, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wn", 32'(mem_wn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", 32'(out_pc), 0);
  endtask

  task automatic test_stream();
    start(1'b1, 0, 40);
    @(negedge clk);
    chk("stream_c0_rd", 32'(mem_rd), 1);
    chk("stream_c0_addr", 32'(mem_address), 0);
    chk("stream_c0_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("stream_c1_valid", 32'(out_valid), 0);
    chk("stream_c1_busy", 32'(busy), 1);
    chk("stream_c1_addr", 32'(mem_address), 1);
    @(negedge clk);
    chk("stream_c2_valid", 32'(out_valid), 1);
    chk("stream_c2_pc", 32'(out_pc), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stream_no_bubble", 32'(out_valid), 1);
    end
    #1;
    chk("stream_count", n_acc, 11);
  endtask

  task automatic test_backpressure();
    start(1'b0, 0, 20);
    repeat (6) @(negedge clk);
    chk("bp_mem_rd", 32'(mem_rd), 0);
    chk("bp_pc", 32'(mem_address), 2);
    chk("bp_busy", 32'(busy), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_head", 32'(out_pc), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("bp_count", n_acc, 8);
  endtask

  task automatic test_redirect();
    start(1'b1, 0, 4);
    for (int i = 0; i < 32; i++) exp_q.push_back(ADDR_W'(16'h0100 + i));
    wait_issue(16'd5, "redir_wait");
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    @(negedge clk);
    chk("redir_busy", 32'(busy), 1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_flush_valid", 32'(out_valid), 0);
    chk("redir_issue_rd", 32'(mem_rd), 1);
    chk("redir_issue_addr", 32'(mem_address), 32'h100);
    @(negedge clk);
    chk("redir_gap_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("redir_first_valid", 32'(out_valid), 1);
    chk("redir_first_pc", 32'(out_pc), 32'h100);
    chk("redir_first_instr", out_instr, 32'hA000_0100);
    repeat (5) @(negedge clk);
    #1;
    chk("redir_count", n_acc, 10);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 16'd2046;
    start(1'b1, 2046, 12);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr_2046", 32'(mem_address), 2046);
    @(negedge clk);
    chk("wrap_addr_2047", 32'(mem_address), 2047);
    @(negedge clk);
    chk("wrap_addr_0", 32'(mem_address), 0);
    repeat (8) @(negedge clk);
    #1;
    chk("wrap_count", n_acc, 9);
  endtask

  task automatic test_halt();
    start(1'b1, 0, 20);
    wait_issue(16'd3, "halt_wait");
    @(posedge clk); #1;
    halt = 1'b1;
    @(negedge clk);
    chk("halt_rd0", 32'(mem_rd), 0);
    chk("halt_busy_inflight", 32'(busy), 1);
    @(negedge clk);
    chk("halt_busy_done", 32'(busy), 0);
    chk("halt_last_valid", 32'(out_valid), 1);
    chk("halt_last_pc", 32'(out_pc), 3);
    repeat (3) @(negedge clk);
    chk("halt_hold_rd", 32'(mem_rd), 0);
    chk("halt_hold_pc", 32'(mem_address), 4);
    chk("halt_drained", 32'(out_valid), 0);
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    chk("halt_resume_rd", 32'(mem_rd), 1);
    chk("halt_resume_addr", 32'(mem_address), 4);
    repeat (6) @(negedge clk);
    #1;
    chk("halt_count", n_acc, 9);
  endtask

  task automatic test_async_reset();
    start(1'b1, 0, 30);
    repeat (4) @(negedge clk);
    chk("arst_pre_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_rd", 32'(mem_rd), 0);
    chk("arst_busy", 32'(busy), 0);
    exp_q.delete();
    n_acc = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(ADDR_W'(i));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arst_restart_rd", 32'(mem_rd), 1);
    chk("arst_restart_addr", 32'(mem_address), 0);
    repeat (4) @(negedge clk);
    #1;
    chk("arst_count", n_acc, 3);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, required completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Read-side initiator for the 2048 x 32 instruction memory.
- Drives the memory's rd/wn/address pins and captures read_data with one-cycle synchronous latency.
- Presents fetched instructions and their PCs to decode over a valid/ready handshake.
- Supports branch redirect and halt; sustains 1 instruction/cycle when decode is always ready.

Parameters:
- ADDR_W, 16, PC and memory address width
- DATA_W, 32, instruction width
- MEM_WORDS, 2048, memory depth; PC wraps at MEM_WORDS-1
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mem_rd  out  1  memory read strobe
- mem_wn  out  1  memory write strobe, constant 0
- mem_address  out  ADDR_W  memory word address (= pc)
- mem_read_data  in  DATA_W  memory read data
- redirect_valid  in  1  load new PC, flush pipeline
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  stop issuing new fetches while high
- out_valid  out  1  out_instr/out_pc valid
- out_ready  in  1  decode accepts the head instruction
- out_instr  out  DATA_W  fetched instruction
- out_pc  out  ADDR_W  address of out_instr
- busy  out  1  a read is in flight

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC; inflight=0; drop=0; FIFO empty.
  - mem_rd=0, mem_wn=0, mem_address=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, busy=0.
  - Reset mid-transaction discards the in-flight read and all buffered entries.
- Memory timing:
  - Issue in cycle t drives mem_rd=1, mem_address=pc.
  - The memory samples at the end of cycle t. mem_read_data holds the word during t+1, and the unit captures it at the end of t+1.
  - At most one read is in flight. The inflight register records the PC of the outstanding read.
- Output buffer:
  - 2-entry FIFO of {instr, pc}.
  - out_valid = FIFO non-empty; out_instr/out_pc = head entry. An empty FIFO holds its last head value.
  - Pop when out_valid & out_ready.
- Issue condition (combinational; mem_rd derives from it):
  - Requires !redirect_valid & !halt.
  - Requires (occupancy + inflight - pop) < 2.
  - On issue, pc <= (pc == MEM_WORDS-1) ? 0 : pc+1.
- Response:
  - In the cycle after an issue, push {mem_read_data, issued pc} unless drop=1.
  - Push and pop in the same cycle are both honoured; occupancy stays unchanged.
- Redirect:
  - In the cycle redirect_valid=1: no issue; FIFO flushed at the clock edge; pc <= redirect_pc.
  - If a response arrives in that cycle, it is discarded.
  - If a read was issued in that cycle's predecessor, drop=1 marks its response for discard.
  - The first fetch of redirect_pc issues the following cycle (if halt=0).
  - Redirect has priority over halt and over pop. out_valid drops to 0 the cycle after the redirect.
  - Back-to-back redirects: the last one wins.
- Halt:
  - While halt=1, no new issue.
  - An in-flight read completes and is pushed normally; the FIFO still drains to decode.
  - Deasserting halt resumes at the current pc with no lost or duplicated address.
- State machine:
  - RUN: issuing allowed.
  - HALTED: halt=1 and inflight=0.
  - RUN->HALTED when halt=1 and no read is outstanding. HALTED->RUN when halt=0.
  - Redirect while HALTED updates pc and flushes, and stays HALTED.
- busy = inflight.
- mem_wn is never asserted, so rd and wn are never both 1.

Test Plan:
- Reset streaming: reset with RESET_PC=0, memory[k]=0xA000_0000+k, out_ready=1 -> mem_rd high from the first cycle after reset; out_valid first at cycle 2; then one instruction per cycle: (pc 0, 0xA0000000), (1, 0xA0000001), ... with no bubbles.
- Backpressure: out_ready=0 after 2 fetches -> FIFO holds pc 0,1, mem_rd=0, pc=2; raise out_ready -> pc 0,1,2,3 delivered in order with no duplicates or gaps.
- Redirect with a read in flight: redirect_valid=1, redirect_pc=0x0100 while pc 5's read is outstanding -> pc 5 is never presented; the next out_pc=0x0100, carrying memory[0x100].
- Wrap: redirect_pc=2046, stream -> out_pc sequence 2046, 2047, 0, 1; mem_address never reaches 2048.
- Halt: assert halt with one read outstanding -> that instruction is delivered, mem_rd stays 0, busy=0; release halt -> fetching resumes at the next sequential pc.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid, mem_rd and busy go 0 immediately; after release, fetch restarts at RESET_PC.
